tpu_seq_ctrl: RTL and testbench

Command sequencer that drives the TPU's memory-mapped port (tpu_addr / tpu_r_w / tpu_dataIn / tpu_dataOut) so software never hand-issues individual bus cycles. On one start pulse it:
- streams DIM A rows, DIM B rows and 2·DIM C half-rows from a valid/ready input stream into the TPU;
- triggers the multiply and waits out the systolic latency;
- streams 2·DIM result half-rows out on a valid/ready output stream.

It sits between the host DMA and the TPU core, and it is the only master of the TPU port.

---
 rtl/tpu_pkg.sv | 31 +++
 rtl/tpu_seq_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_tpu_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU command sequencer.
// The address map and the systolic wait length live here so the sequencer and any future sibling blocks agree.
package tpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_C_LO   = 4'd3,
        S_C_HI   = 4'd4,
        S_C_WR2  = 4'd5,
        S_MUL    = 4'd6,
        S_WAIT   = 4'd7,
        S_READ   = 4'd8
    } seq_state_e;

    localparam logic [15:0] ADDR_A   = 16'h0100;
    localparam logic [15:0] ADDR_B   = 16'h0200;
    localparam logic [15:0] ADDR_C   = 16'h0300;
    localparam logic [15:0] ADDR_MUL = 16'h0400;

    localparam int A_ROW_STRIDE = 8;
    localparam int C_HALF_OFS   = 8;
    localparam int C_ROW_STRIDE = 16;

    // Cycles the array needs after the multiply trigger before results are readable.
    function automatic int wait_len(input int dim);
        return 3 * dim - 1;
    endfunction

endpackage

// File: rtl/tpu_seq_ctrl.sv
// Command sequencer: sole master of the TPU memory-mapped port.
// Streams A, B and C in, triggers the multiply, waits out the array latency and streams results out.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int DIM     = 8,
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load_c,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    localparam int IDXW     = $clog2(2 * DIM) + 1;
    localparam int WAIT_LEN = wait_len(DIM);
    localparam int WCNTW    = $clog2(WAIT_LEN) + 1;

    localparam logic [IDXW-1:0]  LAST_ROW  = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0]  LAST_HALF = IDXW'(2 * DIM - 1);
    localparam logic [WCNTW-1:0] WAIT_LAST = WCNTW'(WAIT_LEN - 1);

    localparam logic [DATAW-1:0] ZERO_ROW  = {DIM{{BITS_AB{1'b0}}}};
    localparam logic [DATAW-1:0] ZERO_HALF = {(DIM / 2){{BITS_C{1'b0}}}};

    seq_state_e       state_q, state_d;
    logic [IDXW-1:0]  index_q, index_d;
    logic [WCNTW-1:0] wait_q, wait_d;
    logic [DATAW-1:0] c_lo_q, c_lo_d;
    logic [DATAW-1:0] c_hi_q, c_hi_d;
    logic             load_c_q, load_c_d;
    logic             done_q, done_d;

    logic [ADDRW-1:0] idx_ext;
    logic [ADDRW-1:0] half_row;
    logic [ADDRW-1:0] a_addr;
    logic [ADDRW-1:0] c_lo_addr;
    logic [ADDRW-1:0] c_hi_addr;
    logic [ADDRW-1:0] rd_addr;

    // In READ the index walks half-rows: bit 0 picks the half, the rest picks the row.
    assign idx_ext   = ADDRW'(index_q);
    assign half_row  = ADDRW'(index_q >> 1);
    assign a_addr    = ADDRW'(ADDR_A) + idx_ext * ADDRW'(A_ROW_STRIDE);
    assign c_lo_addr = ADDRW'(ADDR_C) + idx_ext * ADDRW'(C_ROW_STRIDE);
    assign c_hi_addr = c_lo_addr + ADDRW'(C_HALF_OFS);
    assign rd_addr   = ADDRW'(ADDR_C) + half_row * ADDRW'(C_ROW_STRIDE)
                     + (index_q[0] ? ADDRW'(C_HALF_OFS) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            wait_q   <= '0;
            c_lo_q   <= '0;
            c_hi_q   <= '0;
            load_c_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            wait_q   <= wait_d;
            c_lo_q   <= c_lo_d;
            c_hi_q   <= c_hi_d;
            load_c_q <= load_c_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        wait_d     = wait_q;
        c_lo_d     = c_lo_q;
        c_hi_d     = c_hi_q;
        load_c_d   = load_c_q;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        tpu_r_w    = 1'b0;
        tpu_addr   = '0;
        tpu_dataIn = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD_A;
                    index_d  = '0;
                    load_c_d = load_c;
                end
            end

            S_LOAD_A: begin
                in_ready   = 1'b1;
                tpu_addr   = a_addr;
                tpu_dataIn = in_data;
                if (in_valid) begin
                    tpu_r_w = 1'b1;
                    if (index_q == LAST_ROW) begin
                        state_d = S_LOAD_B;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end

            S_LOAD_B: begin
                in_ready   = 1'b1;
                tpu_addr   = ADDRW'(ADDR_B);
                tpu_dataIn = in_data;
                if (in_valid) begin
                    tpu_r_w = 1'b1;
                    if (index_q == LAST_ROW) begin
                        state_d = load_c_q ? S_C_LO : S_C_HI;
                        index_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end

            S_C_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    c_lo_d  = in_data;
                    state_d = S_C_HI;
                end
            end

            // The low beat is only issued once the high word is in hand, so the
            // TPU always sees low and high on back-to-back cycles.
            S_C_HI: begin
                tpu_addr = c_lo_addr;
                if (load_c_q) begin
                    in_ready   = 1'b1;
                    tpu_dataIn = c_lo_q;
                    if (in_valid) begin
                        tpu_r_w = 1'b1;
                        c_hi_d  = in_data;
                        state_d = S_C_WR2;
                    end
                end else begin
                    tpu_r_w    = 1'b1;
                    tpu_dataIn = ZERO_HALF;
                    state_d    = S_C_WR2;
                end
            end

            S_C_WR2: begin
                tpu_r_w    = 1'b1;
                tpu_addr   = c_hi_addr;
                tpu_dataIn = load_c_q ? c_hi_q : ZERO_HALF;
                if (index_q == LAST_ROW) begin
                    state_d = S_MUL;
                    index_d = '0;
                end else begin
                    state_d = load_c_q ? S_C_LO : S_C_HI;
                    index_d = index_q + 1'b1;
                end
            end

            S_MUL: begin
                tpu_r_w    = 1'b1;
                tpu_addr   = ADDRW'(ADDR_MUL);
                tpu_dataIn = ZERO_ROW;
                state_d    = S_WAIT;
                wait_d     = '0;
            end

            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_READ;
                    index_d = '0;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_READ: begin
                out_valid = 1'b1;
                tpu_addr  = rd_addr;
                if (out_ready) begin
                    if (index_q == LAST_HALF) begin
                        state_d = S_IDLE;
                        index_d = '0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                index_d = '0;
            end
        endcase

        // Abort only rewinds the sequencer; whatever the TPU already holds stays there.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            index_d = '0;
            wait_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign out_data = tpu_dataOut;

    a_no_write_late: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == S_WAIT) || (state_q == S_READ)) |-> !tpu_r_w);

    a_read_addr_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !abort) |=> $stable(tpu_addr));

    a_c_beats_paired: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q == S_C_HI) && tpu_r_w && !abort) |=> (state_q == S_C_WR2));

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: directed jobs run against a behavioural TPU model,
// with a negedge monitor that pops expected results and watches the TPU bus.
module tb_tpu_seq_ctrl;

    localparam int DIM   = 8;
    localparam int DATAW = 64;
    localparam int ADDRW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             load_c = 1'b0;
    logic             abort = 1'b0;
    logic             busy;
    logic             done;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DATAW-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DATAW-1:0] out_data;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    logic [DATAW-1:0] a_mem [DIM];
    logic [DATAW-1:0] b_mem [DIM];
    logic [DATAW-1:0] c_mem [2*DIM];

    int ga [DIM][DIM];
    int gb [DIM][DIM];
    int gc [DIM][DIM];

    logic [DATAW-1:0] in_q [$];
    logic [DATAW-1:0] exp_q [$];

    int in_pct  = 100;
    int rdy_pct = 100;
    int checks  = 0;
    int errors  = 0;
    int mul_count = 0;
    bit post_mul = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_c_lo = 1'b0;
    logic [ADDRW-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    tpu_seq_ctrl #(
        .DIM(DIM), .BITS_AB(8), .BITS_C(16), .ADDRW(ADDRW), .DATAW(DATAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_c(load_c), .abort(abort),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn), .tpu_dataOut(tpu_dataOut)
    );

    // TPU read port: result/C half-rows are visible combinationally at their addresses.
    always_comb begin
        tpu_dataOut = '0;
        if (tpu_addr >= 16'h0300 && tpu_addr < 16'h0380 && tpu_addr[2:0] == 3'd0)
            tpu_dataOut = c_mem[{tpu_addr[6:4], tpu_addr[3]}];
    end

    task automatic checkOutput(input string name, input logic [DATAW-1:0] actual,
                               input logic [DATAW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tpu_multiply();
        logic [DATAW-1:0] res [2*DIM];
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                int acc;
                acc = int'($signed(c_mem[2*i + j/4][16*(j%4) +: 16]));
                for (int k = 0; k < DIM; k++)
                    acc += int'($signed(a_mem[i][8*k +: 8])) * int'($signed(b_mem[k][8*j +: 8]));
                res[2*i + j/4][16*(j%4) +: 16] = acc[15:0];
            end
        end
        for (int r = 0; r < 2*DIM; r++) c_mem[r] = res[r];
    endtask

    task automatic tpu_write(input logic [ADDRW-1:0] addr, input logic [DATAW-1:0] data);
        if (addr >= 16'h0100 && addr < 16'h0140 && addr[2:0] == 3'd0) begin
            a_mem[addr[5:3]] = data;
        end else if (addr == 16'h0200) begin
            for (int i = 0; i < DIM-1; i++) b_mem[i] = b_mem[i+1];
            b_mem[DIM-1] = data;
        end else if (addr >= 16'h0300 && addr < 16'h0380 && addr[2:0] == 3'd0) begin
            c_mem[{addr[6:4], addr[3]}] = data;
        end else if (addr == 16'h0400) begin
            mul_count++;
            post_mul = 1'b1;
            tpu_multiply();
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL write_address: got 0x%0h, required a mapped TPU address", addr);
        end
    endtask

    // Stream drivers change only just after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (in_q.size() > 0 && int'($urandom_range(99)) < in_pct) begin
            in_valid = 1'b1;
            in_data  = in_q[0];
        end else begin
            in_valid = 1'b0;
        end
        out_ready = (int'($urandom_range(99)) < rdy_pct);
    end

    // Monitor: everything sampled here is what the coming posedge will commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            post_mul   = 1'b0;
            prev_stall = 1'b0;
            prev_c_lo  = 1'b0;
        end else begin
            if (in_valid && in_ready && in_q.size() > 0) void'(in_q.pop_front());
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL out_extra: got 0x%0h, required no output", out_data);
                end else begin
                    checkOutput("out_data", out_data, exp_q.pop_front());
                end
            end
            if (prev_stall && out_valid) checkOutput("addr_hold", tpu_addr, prev_addr);
            if (post_mul && busy) checkOutput("no_write_after_mul", tpu_r_w, 1'b0);
            if (prev_c_lo) checkOutput("c_hi_follows_lo", {tpu_r_w, tpu_addr}, {1'b1, prev_addr + 16'd8});
            if (tpu_r_w) tpu_write(tpu_addr, tpu_dataIn);
            if (!busy) post_mul = 1'b0;
            prev_stall = out_valid && !out_ready;
            prev_c_lo  = tpu_r_w && tpu_addr >= 16'h0300 && tpu_addr < 16'h0380 && !tpu_addr[3];
            prev_addr  = tpu_addr;
        end
    end

    task automatic setup_ident_ramp(input int cval);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ga[i][j] = (i == j) ? 1 : 0;
                gb[i][j] = 8*i + j;
                gc[i][j] = cval;
            end
    endtask

    task automatic setup_random(input bit with_c);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ga[i][j] = int'($urandom_range(255)) - 128;
                gb[i][j] = int'($urandom_range(255)) - 128;
                gc[i][j] = with_c ? int'($urandom_range(65535)) - 32768 : 0;
            end
    endtask

    task automatic push_stream(input bit lc);
        logic [DATAW-1:0] w;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) w[8*j +: 8] = 8'(ga[i][j]);
            in_q.push_back(w);
        end
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) w[8*j +: 8] = 8'(gb[i][j]);
            in_q.push_back(w);
        end
        if (lc)
            for (int i = 0; i < DIM; i++)
                for (int h = 0; h < 2; h++) begin
                    for (int p = 0; p < 4; p++) w[16*p +: 16] = 16'(gc[i][4*h + p]);
                    in_q.push_back(w);
                end
    endtask

    // Identity times ramp: every result element is simply its ramp value plus C.
    task automatic push_ramp_expected(input int cval);
        logic [DATAW-1:0] w;
        for (int i = 0; i < DIM; i++)
            for (int h = 0; h < 2; h++) begin
                for (int p = 0; p < 4; p++) w[16*p +: 16] = 16'(8*i + 4*h + p + cval);
                exp_q.push_back(w);
            end
    endtask

    task automatic push_golden();
        logic [DATAW-1:0] w;
        for (int i = 0; i < DIM; i++)
            for (int h = 0; h < 2; h++) begin
                for (int p = 0; p < 4; p++) begin
                    int acc;
                    acc = gc[i][4*h + p];
                    for (int k = 0; k < DIM; k++) acc += ga[i][k] * gb[k][4*h + p];
                    w[16*p +: 16] = 16'(acc);
                end
                exp_q.push_back(w);
            end
    endtask

    // Runs one job; cycle n=1 is the first cycle after the edge that samples start.
    task automatic applyStimulus(input bit lc, input int abort_cyc, input int rst_cyc,
                                 input int dup_start_cyc, input int exp_done_edges);
        int n;
        int done_n;
        int done_cnt;
        bit stopped;
        mul_count = 0;
        done_n    = 0;
        done_cnt  = 0;
        stopped   = 1'b0;
        @(posedge clk); #1;
        start  = 1'b1;
        load_c = lc;
        @(posedge clk); #1;
        start  = 1'b0;
        load_c = 1'b0;
        n = 1;
        while (!stopped) begin
            abort  = (n == abort_cyc);
            start  = (n == dup_start_cyc);
            load_c = (n == dup_start_cyc) ? !lc : 1'b0;
            if (n == rst_cyc) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("rst_busy", busy, 1'b0);
                checkOutput("rst_done", done, 1'b0);
                checkOutput("rst_in_ready", in_ready, 1'b0);
                checkOutput("rst_out_valid", out_valid, 1'b0);
                checkOutput("rst_r_w", tpu_r_w, 1'b0);
                checkOutput("rst_addr", tpu_addr, 16'h0);
                checkOutput("rst_dataIn", tpu_dataIn, 64'h0);
                checkOutput("rst_out_data", out_data, 64'h0);
                #2;
                rst_n   = 1'b1;
                stopped = 1'b1;
            end else begin
                @(negedge clk);
                if (done) begin
                    done_cnt++;
                    if (done_n == 0) done_n = n;
                end
                if (abort_cyc > 0 && n == abort_cyc + 1) begin
                    checkOutput("abort_busy", busy, 1'b0);
                    checkOutput("abort_r_w", tpu_r_w, 1'b0);
                    checkOutput("abort_in_ready", in_ready, 1'b0);
                    checkOutput("abort_out_valid", out_valid, 1'b0);
                    checkOutput("abort_done", done, 1'b0);
                end
                if (abort_cyc > 0 && n == abort_cyc + 4) stopped = 1'b1;
                if (abort_cyc == 0 && done_n != 0 && n == done_n + 2) stopped = 1'b1;
                if (n >= 3000) begin
                    checkOutput("job_finished", 1'b0, 1'b1);
                    stopped = 1'b1;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        abort  = 1'b0;
        start  = 1'b0;
        load_c = 1'b0;
        if (abort_cyc == 0 && rst_cyc == 0) begin
            checkOutput("done_pulses", done_cnt, 1);
            checkOutput("mul_writes", mul_count, 1);
            checkOutput("outputs_left", exp_q.size(), 0);
            checkOutput("inputs_left", in_q.size(), 0);
            if (exp_done_edges > 0) checkOutput("done_latency", done_n - 1, exp_done_edges);
        end else begin
            checkOutput("no_done_interrupted", done_cnt, 0);
        end
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int r = 0; r < 2*DIM; r++) c_mem[r] = '0;
        for (int r = 0; r < DIM; r++) begin
            a_mem[r] = '0;
            b_mem[r] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_r_w", tpu_r_w, 1'b0);
        checkOutput("reset_addr", tpu_addr, 16'h0);
        checkOutput("reset_dataIn", tpu_dataIn, 64'h0);
        rst_n = 1'b1;

        $display("[TB] identity x ramp, C zeroed");
        setup_ident_ramp(0); push_stream(1'b0); push_ramp_expected(0);
        applyStimulus(1'b0, 0, 0, 0, 72);

        $display("[TB] identity x ramp, C streamed as ones");
        setup_ident_ramp(1); push_stream(1'b1); push_ramp_expected(1);
        applyStimulus(1'b1, 0, 0, 0, 80);

        $display("[TB] signed random with throttled streams");
        in_pct = 50; rdy_pct = 30;
        setup_random(1'b1); push_stream(1'b1); push_golden();
        applyStimulus(1'b1, 0, 0, 0, 0);
        in_pct = 100; rdy_pct = 100;

        $display("[TB] abort in LOAD_B and in WAIT, then a clean job");
        setup_ident_ramp(0); push_stream(1'b0);
        applyStimulus(1'b0, 12, 0, 0, 0);
        push_stream(1'b0);
        applyStimulus(1'b0, 44, 0, 0, 0);
        setup_random(1'b0); push_stream(1'b0); push_golden();
        applyStimulus(1'b0, 0, 0, 0, 72);

        $display("[TB] reset during READ, then restart");
        setup_ident_ramp(0); push_stream(1'b0); push_ramp_expected(0);
        applyStimulus(1'b0, 0, 60, 0, 0);
        setup_ident_ramp(2); push_stream(1'b1); push_ramp_expected(2);
        applyStimulus(1'b1, 0, 0, 0, 80);

        $display("[TB] start repeated during LOAD_A");
        setup_ident_ramp(0); push_stream(1'b0); push_ramp_expected(0);
        applyStimulus(1'b0, 0, 0, 3, 72);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
